// File: rtl/button_conditioner.sv
// Debounce, edge-pulse and long-press conditioning for three active-low push buttons.
// Each button is an independent lane: synchronizer, debounce FSM, and a saturating hold counter.

module button_conditioner_lane #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel,
  output logic held
);
  localparam logic [23:0] D_LAST = 24'(DEBOUNCE_CYCLES - 1);
  localparam logic [27:0] H_LAST = 28'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

  state_t      state;
  logic [1:0]  sync;
  logic [23:0] dcnt;
  logic [27:0] hcnt;
  logic        s;

  assign s = sync[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync  <= 2'b11;
      state <= IDLE;
      dcnt  <= '0;
      hcnt  <= '0;
      level <= 1'b1;
      press <= 1'b0;
      rel   <= 1'b0;
      held  <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      press <= 1'b0;
      rel   <= 1'b0;
      held  <= 1'b0;
      case (state)
        IDLE: begin
          if (!s) begin
            state <= PRESS_WAIT;
            dcnt  <= '0;
          end
        end
        PRESS_WAIT: begin
          if (s) begin
            state <= IDLE;
          end else if (dcnt == D_LAST) begin
            state <= PRESSED;
            hcnt  <= '0;
            press <= 1'b1;
            level <= 1'b0;
          end else begin
            dcnt <= dcnt + 24'd1;
          end
        end
        PRESSED: begin
          if (s) begin
            state <= RELEASE_WAIT;
            dcnt  <= '0;
          end else if (hcnt != H_LAST) begin
            // Pulse only on the step into saturation, so a press yields at most one.
            hcnt <= hcnt + 28'd1;
            if (hcnt == H_LAST - 28'd1) held <= 1'b1;
          end
        end
        RELEASE_WAIT: begin
          // A bounce back low resumes the press with hcnt intact.
          if (!s) begin
            state <= PRESSED;
          end else if (dcnt == D_LAST) begin
            state <= IDLE;
            rel   <= 1'b1;
            level <= 1'b1;
          end else begin
            dcnt <= dcnt + 24'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] btn_raw,
  output logic [2:0] btn_level,
  output logic [2:0] btn_press,
  output logic [2:0] btn_release,
  output logic [2:0] btn_long
);
  localparam int NUM_LANES = 3;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    button_conditioner_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES)
    ) u_lane (
      .clk  (clk),
      .reset(reset),
      .raw  (btn_raw[i]),
      .level(btn_level[i]),
      .press(btn_press[i]),
      .rel  (btn_release[i]),
      .held (btn_long[i])
    );
  end
endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
// Inputs change 1ns after a rising edge; outputs are sampled at the same point.

module tb_button_conditioner;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] btn_raw = 3'b111;
  logic [2:0] btn_level, btn_press, btn_release, btn_long;

  int checks = 0;
  int failures = 0;
  int np [3];
  int nr [3];
  int nl [3];
  logic [2:0] lvl_hi_seen;

  button_conditioner #(.DEBOUNCE_CYCLES(4), .LONG_CYCLES(20)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_long   (btn_long)
  );

  always #5 clk = ~clk;

  task automatic clr();
    for (int i = 0; i < 3; i++) begin
      np[i] = 0; nr[i] = 0; nl[i] = 0;
    end
    lvl_hi_seen = 3'b000;
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        np[i] += int'(btn_press[i]);
        nr[i] += int'(btn_release[i]);
        nl[i] += int'(btn_long[i]);
      end
      lvl_hi_seen |= btn_level;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_counts(input string tag, input logic [2:0] ep, input logic [2:0] er,
                            input logic [2:0] el);
    logic [2:0] op, orl, ol;
    for (int i = 0; i < 3; i++) begin
      op[i]  = (np[i] == int'(ep[i]));
      orl[i] = (nr[i] == int'(er[i]));
      ol[i]  = (nl[i] == int'(el[i]));
    end
    chk({tag, "_press_cnt"},   {29'd0, op},  32'h7);
    chk({tag, "_release_cnt"}, {29'd0, orl}, 32'h7);
    chk({tag, "_long_cnt"},    {29'd0, ol},  32'h7);
  endtask

  initial begin
    clr();
    // Reset state
    tick(3);
    chk("rst_level", 32'(btn_level), 32'h7);
    chk("rst_press", 32'(btn_press), 32'h0);
    chk("rst_release", 32'(btn_release), 32'h0);
    chk("rst_long", 32'(btn_long), 32'h0);
    reset = 1'b0;
    tick(2);
    clr();

    // Clean press on bit 0: pulse after edge E+6
    btn_raw = 3'b110;
    tick(6);                      // edges E..E+5
    chk("p0_early_level", 32'(btn_level), 32'h7);
    chk("p0_early_press", np[0], 0);
    tick(1);                      // E+6
    chk("p0_level", 32'(btn_level), 32'h6);
    chk("p0_press", 32'(btn_press), 32'h1);
    tick(1);
    chk("p0_press_one_cycle", 32'(btn_press), 32'h0);
    btn_raw = 3'b111;             // release, next edge R
    tick(6);
    chk("r0_early_level", 32'(btn_level), 32'h6);
    tick(1);                      // R+6
    chk("r0_level", 32'(btn_level), 32'h7);
    chk("r0_release", 32'(btn_release), 32'h1);
    tick(1);
    chk("r0_release_one_cycle", 32'(btn_release), 32'h0);
    chk_counts("p0", 3'b001, 3'b001, 3'b000);

    // Bounce on bit 1: low 2 / high 2 for 20 cycles
    clr();
    for (int k = 0; k < 5; k++) begin
      btn_raw[1] = 1'b0; tick(2);
      btn_raw[1] = 1'b1; tick(2);
    end
    tick(10);
    chk("bounce_level", 32'(btn_level), 32'h7);
    chk_counts("bounce", 3'b000, 3'b000, 3'b000);

    // Long press on bit 2: press at P=E+6, long at P+19, release after 6
    clr();
    btn_raw[2] = 1'b0;
    tick(7);                      // E..E+6
    chk("l2_press", 32'(btn_press), 32'h4);
    chk("l2_level", 32'(btn_level), 32'h3);
    tick(18);                     // P+18
    chk("l2_long_early", nl[2], 0);
    tick(1);                      // P+19
    chk("l2_long", 32'(btn_long), 32'h4);
    tick(1);
    chk("l2_long_one_cycle", 32'(btn_long), 32'h0);
    tick(14);
    btn_raw[2] = 1'b1;            // release, next edge R
    tick(6);
    chk("l2_release_early", nr[2], 0);
    tick(1);                      // R+6
    chk("l2_release", 32'(btn_release), 32'h4);
    chk("l2_level_after", 32'(btn_level), 32'h7);
    tick(3);
    chk_counts("long2", 3'b100, 3'b100, 3'b100);

    // Release glitch on bit 0
    clr();
    btn_raw[0] = 1'b0;
    tick(7);
    chk("g0_press", 32'(btn_press), 32'h1);
    tick(3);
    lvl_hi_seen = 3'b000;
    btn_raw[0] = 1'b1;            // edge R
    tick(3);                      // R..R+2
    btn_raw[0] = 1'b0;
    tick(2);                      // R+3, R+4 sample low
    btn_raw[0] = 1'b1;            // stable release from R+5
    tick(6);                      // R+5..R+10
    chk("g0_level_held", 32'(lvl_hi_seen[0]), 32'h0);
    chk("g0_no_early_release", nr[0], 0);
    tick(1);                      // R+11 = (R+5)+6
    chk("g0_release", 32'(btn_release), 32'h1);
    chk("g0_level_after", 32'(btn_level), 32'h7);
    tick(3);
    chk_counts("glitch0", 3'b001, 3'b001, 3'b000);

    // Simultaneous press on bits 0 and 1
    clr();
    btn_raw = 3'b100;
    tick(6);
    chk("s01_early", 32'(btn_press), 32'h0);
    tick(1);
    chk("s01_press", 32'(btn_press), 32'h3);
    chk("s01_level", 32'(btn_level), 32'h4);
    btn_raw = 3'b111;
    tick(10);
    chk("s01_level_after", 32'(btn_level), 32'h7);
    chk_counts("simul01", 3'b011, 3'b011, 3'b000);

    // Reset during PRESS_WAIT with bit 0 held low
    clr();
    btn_raw[0] = 1'b0;            // edge E
    tick(4);                      // E..E+3, FSM in PRESS_WAIT
    reset = 1'b1;
    tick(1);
    chk("mr_level", 32'(btn_level), 32'h7);
    chk("mr_pulses", 32'({btn_press, btn_release, btn_long}), 32'h0);
    reset = 1'b0;
    clr();
    tick(6);                      // F..F+5
    chk("mr_no_early_press", np[0], 0);
    tick(1);                      // F+6
    chk("mr_press", 32'(btn_press), 32'h1);
    chk("mr_level_pressed", 32'(btn_level), 32'h6);
    btn_raw = 3'b111;
    tick(10);
    chk_counts("midreset", 3'b001, 3'b001, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
